optical_tx_scheduler: RTL

- Sequences the optical transmitter inside the transceiver. It shares the single serializer between two requesters: a host byte stream (UART receive path) and an internal idle/keep-alive generator.
- Buffers host bytes in a small FIFO and issues one-cycle `tx_wr` strobes with `tx_data`.
- Waits out the serializer's busy window, then enforces an inter-byte guard gap so the optical receiver can resynchronise.

---
 rtl/optical_tx_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/optical_tx_scheduler.sv
// ---------------------------------------------------------------------------
// optical_tx_scheduler
//
// Shares the optical serializer between the host byte stream and an internal
// keep-alive generator. Host bytes are buffered in a small FIFO; each issued
// byte produces a one-cycle tx_wr strobe. The scheduler then waits for the
// serializer's busy window to open and close. Finally it holds off for a
// guard gap so the far-end receiver can resynchronise.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   host_valid   host byte offered this cycle
//   host_data    host byte
//   host_ready   FIFO can accept a byte (registered from occupancy)
//   tx_wr        one-cycle write strobe to the serializer
//   tx_data      byte presented to the serializer, held until next issue
//   tx_busy      serializer is shifting a byte
//   fifo_count   current FIFO occupancy
//   overflow     sticky: byte offered while host_ready was low (byte dropped)
//   timeout_err  sticky: tx_busy never rose within BUSY_TIMEOUT cycles
//   sched_busy   scheduler is anywhere other than IDLE
// ---------------------------------------------------------------------------
module optical_tx_scheduler #(
  parameter int         FIFO_DEPTH   = 4,
  parameter int         IDLE_CYCLES  = 1000000,
  parameter logic [7:0] IDLE_BYTE    = 8'hAA,
  parameter int         GUARD_CYCLES = 16,
  parameter int         BUSY_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_valid,
  input  logic [7:0]                    host_data,
  output logic                          host_ready,
  output logic                          tx_wr,
  output logic [7:0]                    tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout_err,
  output logic                          sched_busy
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int ICW = $clog2(IDLE_CYCLES + 1);
  localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW  = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GUARD     = 3'd4
  } state_t;

  state_t state;

  // -------------------------------------------------------------------------
  // Host FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  assign push = host_valid & host_ready;
  // Host bytes always win over keep-alive, so any queued byte is taken the
  // moment the scheduler is idle.
  assign pop  = (state == S_IDLE) && (fifo_count != '0);

  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CW'(1);
      2'b01:   count_nxt = fifo_count - CW'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // Storage carries no reset: stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      host_ready <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);   // power-of-2 depth: natural wrap
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_nxt;
      // Registered ready: a full FIFO keeps rejecting for one cycle even if
      // a pop frees a slot in the same cycle.
      host_ready <= (count_nxt < CW'(FIFO_DEPTH));
      if (host_valid && !host_ready) overflow <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Issue sequencer
  // -------------------------------------------------------------------------
  logic [ICW-1:0] idle_cnt;
  logic [TW-1:0]  wait_cnt;
  logic [GW-1:0]  guard_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tx_wr       <= 1'b0;
      tx_data     <= 8'h00;
      idle_cnt    <= '0;
      wait_cnt    <= '0;
      guard_cnt   <= '0;
      timeout_err <= 1'b0;
      sched_busy  <= 1'b0;
    end else begin
      tx_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            tx_data    <= mem[rd_ptr];
            idle_cnt   <= '0;
            state      <= S_ISSUE;
            sched_busy <= 1'b1;
          end else if (idle_cnt == ICW'(IDLE_CYCLES - 1)) begin
            tx_data    <= IDLE_BYTE;
            idle_cnt   <= '0;
            state      <= S_ISSUE;
            sched_busy <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + ICW'(1);
          end
        end

        // Strobe is registered, so it is seen during the first WAIT_BUSY
        // cycle; the busy-rise window is counted from that same cycle.
        S_ISSUE: begin
          tx_wr    <= 1'b1;
          wait_cnt <= '0;
          state    <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (wait_cnt == TW'(BUSY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            guard_cnt   <= '0;
            state       <= S_GUARD;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        // A byte takes ~10 baud periods; a stuck-high busy is not policed.
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            guard_cnt <= '0;
            state     <= S_GUARD;
          end
        end

        S_GUARD: begin
          if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
            state      <= S_IDLE;
            sched_busy <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end

        default: begin
          state      <= S_IDLE;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
